// File: rtl/scalar_reg_file_param_if.sv
// Bus between decode/writeback and the scalar register file: write port, read ports,
// scoreboard marking and the clear-all handshake.
interface scalar_reg_file_param_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned NUM_READ = 2
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic                       we;
    logic [AW-1:0]              wa;
    logic [DATA_W-1:0]          wd;
    logic [NUM_READ*AW-1:0]     ra;
    logic [NUM_READ*DATA_W-1:0] rd;
    logic [DATA_W-1:0]          pc_in;
    logic                       mark_en;
    logic [AW-1:0]              mark_addr;
    logic [NUM_REGS-1:0]        pending;
    logic                       clr_req;
    logic                       clr_busy;

    modport master (
        output we, wa, wd, ra, pc_in, mark_en, mark_addr, clr_req,
        input  rd, pending, clr_busy
    );

    modport slave (
        input  we, wa, wd, ra, pc_in, mark_en, mark_addr, clr_req,
        output rd, pending, clr_busy
    );
endinterface

// File: rtl/scalar_reg_file_param.sv
// Parametrised scalar register file: combinational reads with PC/R0 aliasing and optional
// write bypass, one synchronous write port, pending scoreboard and a sequenced clear-all.
module scalar_reg_file_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned PC_IDX   = 7,
    parameter int unsigned ZERO_R0  = 0,
    parameter int unsigned BYPASS   = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    scalar_reg_file_param_if.slave  bus
);
    localparam int unsigned   AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0] PC_ADDR  = AW'(PC_IDX);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam bit            ZERO_EN  = (ZERO_R0 != 0);
    localparam bit            BYP_EN   = (BYPASS != 0);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                clr_busy;
    logic                commit;
    logic                mark_ok;

    assign clr_busy = (state_q == StClear);
    assign commit   = bus.we && !clr_busy && (bus.wa != PC_ADDR) && !(ZERO_EN && bus.wa == '0);
    assign mark_ok  = bus.mark_en && !clr_busy && (bus.mark_addr != PC_ADDR) &&
                      !(ZERO_EN && bus.mark_addr == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Mark is applied after the writeback clear so a new producer wins on the same register.
    always_comb begin
        pending_d = pending_q;
        if (clr_busy) begin
            pending_d[cnt_q] = 1'b0;
        end else begin
            if (commit)  pending_d[bus.wa]        = 1'b0;
            if (mark_ok) pending_d[bus.mark_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (clr_busy) begin
            regs_q[cnt_q] <= '0;
        end else if (commit) begin
            regs_q[bus.wa] <= bus.wd;
        end
    end

    logic [NUM_READ*DATA_W-1:0] rd_flat;
    logic [AW-1:0]              ra_i;

    // commit is already low during CLEAR, so the bypass is naturally suppressed there.
    always_comb begin
        rd_flat = '0;
        ra_i    = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra_i = bus.ra[i*AW +: AW];
            if (ra_i == PC_ADDR) begin
                rd_flat[i*DATA_W +: DATA_W] = bus.pc_in;
            end else if (ZERO_EN && ra_i == '0) begin
                rd_flat[i*DATA_W +: DATA_W] = '0;
            end else if (BYP_EN && commit && bus.wa == ra_i) begin
                rd_flat[i*DATA_W +: DATA_W] = bus.wd;
            end else begin
                rd_flat[i*DATA_W +: DATA_W] = regs_q[ra_i];
            end
        end
    end

    assign bus.rd       = rd_flat;
    assign bus.pending  = pending_q;
    assign bus.clr_busy = clr_busy;
endmodule

// File: tb/tb_scalar_reg_file_param.sv
// Bench for scalar_reg_file_param: instance A (bypass, no R0 hardwire) and instance B
// (no bypass, R0 hardwired) driven identically; directed table, corner sequences, random.
module tb_scalar_reg_file_param;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra0, ra1;
    logic [15:0] pc;
    logic        mark_en;
    logic [2:0]  mark_addr;
    logic        clr_req;

    int n_tests;
    int n_fail;

    scalar_reg_file_param_if #(.DATA_W(16), .NUM_REGS(8), .NUM_READ(2)) ifa ();
    scalar_reg_file_param_if #(.DATA_W(16), .NUM_REGS(8), .NUM_READ(2)) ifb ();

    assign ifa.we = we;          assign ifb.we = we;
    assign ifa.wa = wa;          assign ifb.wa = wa;
    assign ifa.wd = wd;          assign ifb.wd = wd;
    assign ifa.ra = {ra1, ra0};  assign ifb.ra = {ra1, ra0};
    assign ifa.pc_in = pc;       assign ifb.pc_in = pc;
    assign ifa.mark_en = mark_en;      assign ifb.mark_en = mark_en;
    assign ifa.mark_addr = mark_addr;  assign ifb.mark_addr = mark_addr;
    assign ifa.clr_req = clr_req;      assign ifb.clr_req = clr_req;

    scalar_reg_file_param #(
        .DATA_W(16), .NUM_REGS(8), .NUM_READ(2), .PC_IDX(7), .ZERO_R0(0), .BYPASS(1)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    scalar_reg_file_param #(
        .DATA_W(16), .NUM_REGS(8), .NUM_READ(2), .PC_IDX(7), .ZERO_R0(1), .BYPASS(0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents, pending sets and remaining clear cycles.
    logic [15:0] ma [8];
    logic [15:0] mb [8];
    logic [7:0]  pa, pb;
    int          m_left, m_idx;

    function automatic void model_reset();
        for (int r = 0; r < 8; r++) begin
            ma[r] = '0;
            mb[r] = '0;
        end
        pa = '0; pb = '0; m_left = 0; m_idx = 0;
    endfunction

    function automatic void model_update();
        if (m_left > 0) begin
            ma[m_idx] = '0; mb[m_idx] = '0;
            pa[m_idx] = 1'b0; pb[m_idx] = 1'b0;
            m_idx++; m_left--;
        end else begin
            if (we && wa != 3'd7) begin ma[wa] = wd; pa[wa] = 1'b0; end
            if (we && wa != 3'd7 && wa != 3'd0) begin mb[wa] = wd; pb[wa] = 1'b0; end
            if (mark_en && mark_addr != 3'd7) pa[mark_addr] = 1'b1;
            if (mark_en && mark_addr != 3'd7 && mark_addr != 3'd0) pb[mark_addr] = 1'b1;
            if (clr_req) begin m_left = 8; m_idx = 0; end
        end
    endfunction

    function automatic logic [15:0] exp_rd(input bit alt, input logic [2:0] a);
        if (a == 3'd7) return pc;
        if (alt && a == 3'd0) return 16'h0000;
        if (!alt && m_left == 0 && we && wa == a) return wd;
        return alt ? mb[a] : ma[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rd0_a", 32'(ifa.rd[15:0]),  32'(exp_rd(1'b0, ra0)));
        chk("rd1_a", 32'(ifa.rd[31:16]), 32'(exp_rd(1'b0, ra1)));
        chk("rd0_b", 32'(ifb.rd[15:0]),  32'(exp_rd(1'b1, ra0)));
        chk("rd1_b", 32'(ifb.rd[31:16]), 32'(exp_rd(1'b1, ra1)));
        chk("pend_a", 32'(ifa.pending), 32'(pa));
        chk("pend_b", 32'(ifb.pending), 32'(pb));
        chk("busy_a", 32'(ifa.clr_busy), 32'(m_left > 0));
        chk("busy_b", 32'(ifb.clr_busy), 32'(m_left > 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = '0; wd = '0; mark_en = 1'b0; mark_addr = '0; clr_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic [15:0] pc;
        logic        mark_en;
        logic [2:0]  mark_addr;
        logic [15:0] e_rd0_a;
        logic [15:0] e_rd1_a;
        logic [15:0] e_rd0_b;
        logic [7:0]  e_pend_a;
        logic [7:0]  e_pend_b;
    } vec_t;

    vec_t vecs [13];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        // Outputs are checked before the edge the vector's inputs act on.
        vecs[0]  = '{1'b1, 3'd4, 16'h1CA7, 3'd4, 3'd7, 16'h0040, 1'b0, 3'd0,
                     16'h1CA7, 16'h0040, 16'h0000, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 3'd4, 3'd4, 16'h0012, 1'b0, 3'd0,
                     16'h1CA7, 16'h1CA7, 16'h1CA7, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd7, 16'h0012, 1'b0, 3'd0,
                     16'h0012, 16'h0012, 16'h0012, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h0012, 1'b0, 3'd0,
                     16'h0000, 16'h0012, 16'h0000, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 3'd0, 16'h5555, 3'd0, 3'd0, 16'h0012, 1'b0, 3'd0,
                     16'h5555, 16'h5555, 16'h0000, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'h0012, 1'b0, 3'd0,
                     16'h5555, 16'h5555, 16'h0000, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'h0012, 1'b1, 3'd3,
                     16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 3'd3, 16'h0033, 3'd4, 3'd7, 16'h0012, 1'b1, 3'd3,
                     16'h1CA7, 16'h0012, 16'h1CA7, 8'h08, 8'h08};
        vecs[8]  = '{1'b1, 3'd3, 16'h0034, 3'd3, 3'd3, 16'h0012, 1'b0, 3'd0,
                     16'h0034, 16'h0034, 16'h0033, 8'h08, 8'h08};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'h0012, 1'b1, 3'd7,
                     16'h0034, 16'h0000, 16'h0034, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h1234, 1'b1, 3'd0,
                     16'h5555, 16'h1234, 16'h0000, 8'h00, 8'h00};
        vecs[11] = '{1'b1, 3'd0, 16'h0001, 3'd0, 3'd1, 16'h1234, 1'b0, 3'd0,
                     16'h0001, 16'h0000, 16'h0000, 8'h01, 8'h00};
        vecs[12] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 16'h1234, 1'b0, 3'd0,
                     16'h0001, 16'h0034, 16'h0000, 8'h00, 8'h00};

        idle_inputs();
        ra0 = '0; ra1 = '0; pc = 16'h0040;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset contents on every index, both ports, both instances.
        for (int r = 0; r < 8; r++) begin
            ra0 = 3'(r); ra1 = 3'(7 - r);
            #1;
            chk("reset_rd0_a", 32'(ifa.rd[15:0]),  (r == 7) ? 32'h0040 : 32'h0);
            chk("reset_rd1_a", 32'(ifa.rd[31:16]), (r == 0) ? 32'h0040 : 32'h0);
            chk("reset_rd0_b", 32'(ifb.rd[15:0]),  (r == 7) ? 32'h0040 : 32'h0);
        end
        chk("reset_pend", 32'(ifa.pending), 32'h0);
        chk("reset_busy", 32'(ifa.clr_busy), 32'h0);
        @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
            ra0 = vecs[v].ra0; ra1 = vecs[v].ra1; pc = vecs[v].pc;
            mark_en = vecs[v].mark_en; mark_addr = vecs[v].mark_addr;
            #1;
            chk($sformatf("vec%0d_rd0_a", v), 32'(ifa.rd[15:0]),  32'(vecs[v].e_rd0_a));
            chk($sformatf("vec%0d_rd1_a", v), 32'(ifa.rd[31:16]), 32'(vecs[v].e_rd1_a));
            chk($sformatf("vec%0d_rd0_b", v), 32'(ifb.rd[15:0]),  32'(vecs[v].e_rd0_b));
            chk($sformatf("vec%0d_pend_a", v), 32'(ifa.pending), 32'(vecs[v].e_pend_a));
            chk($sformatf("vec%0d_pend_b", v), 32'(ifb.pending), 32'(vecs[v].e_pend_b));
            tick();
        end
        idle_inputs();

        // Clear-all: fill R0..R6, mark R5, run the sequence with a late write and mark.
        for (int r = 0; r < 7; r++) begin
            we = 1'b1; wa = 3'(r); wd = 16'h0100 + 16'(r);
            mark_en = (r == 6); mark_addr = 3'd5;
            tick();
        end
        idle_inputs();
        #1;
        chk("pre_clr_pend", 32'(ifa.pending), 32'h20);
        ra0 = 3'd6; #1;
        chk("pre_clr_r6", 32'(ifa.rd[15:0]), 32'h0106);
        clr_req = 1'b1;
        #1;
        chk("clr_req_busy", 32'(ifa.clr_busy), 32'h0);
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            clr_req = (c == 1);
            if (c == 4) begin
                we = 1'b1; wa = 3'd2; wd = 16'hBEEF; ra0 = 3'd2;
                #1;
                chk("clr_no_bypass", 32'(ifa.rd[15:0]), 32'h0);
            end
            mark_en = (c == 7); mark_addr = 3'd1;
            #1;
            chk($sformatf("clr_busy_c%0d", c), 32'(ifa.clr_busy), 32'h1);
            tick();
            idle_inputs();
        end
        #1;
        chk("post_clr_busy", 32'(ifa.clr_busy), 32'h0);
        chk("post_clr_pend", 32'(ifa.pending), 32'h0);
        for (int r = 0; r < 7; r++) begin
            ra0 = 3'(r); #1;
            chk($sformatf("post_clr_r%0d", r), 32'(ifa.rd[15:0]), 32'h0);
        end
        @(negedge clk);

        // Reset mid-CLEAR aborts the sequence.
        we = 1'b1; wa = 3'd6; wd = 16'h6666;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (3) tick();
        #1;
        chk("abort_busy_before", 32'(ifa.clr_busy), 32'h1);
        ra0 = 3'd6; #1;
        chk("abort_r6_before", 32'(ifa.rd[15:0]), 32'h6666);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_busy", 32'(ifa.clr_busy), 32'h0);
        chk("abort_r6", 32'(ifa.rd[15:0]), 32'h0);
        chk("abort_pend", 32'(ifa.pending), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("abort_no_resume", 32'(ifa.clr_busy), 32'h0);
        we = 1'b1; wa = 3'd1; wd = 16'h0A0A;
        tick();
        idle_inputs();
        ra0 = 3'd1; #1;
        chk("abort_r1", 32'(ifa.rd[15:0]), 32'h0A0A);
        @(negedge clk);

        // Random traffic against the model, starting from a fresh reset.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            we        = ($urandom_range(0, 1) == 1);
            wa        = 3'($urandom_range(0, 7));
            wd        = 16'($urandom);
            ra0       = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            ra1       = 3'($urandom_range(0, 7));
            pc        = 16'($urandom);
            mark_en   = ($urandom_range(0, 2) == 0);
            mark_addr = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            clr_req   = ($urandom_range(0, 39) == 0);
            #1;
            check_all();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
